// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the down_counter slice.
//   state_t   - FSM state encoding (IDLE/COUNT/DONE); 2'b11 is unused
//   DEF_WIDTH - default count / load-value width
package counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/dcnt_reg.sv
// dcnt_reg: count register with load / decrement / hold mux.
//   clk, rst_n - clock, async active-low reset (clears q)
//   ld, ld_val - load request and value (wins over dec)
//   dec        - decrement request; saturates at 0
//   q          - registered count
import counter_pkg::*;

module dcnt_reg #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (ld)               q <= ld_val;
    else if (dec && q != '0)   q <= q - WIDTH'(1);
  end

endmodule

// File: rtl/down_counter.sv
// down_counter: loadable down counter with start/hold/auto-reload control.
//   clk         - clock, rising edge
//   RESET       - async active-low reset
//   load        - load q and reload_reg from load_val, go IDLE (top priority)
//   start       - begin countdown (IDLE only)
//   hold        - freeze count in COUNT
//   auto_reload - in DONE, reload from reload_reg and continue
//   q           - registered count
//   busy        - high in COUNT and DONE
//   tc          - high while in DONE (one cycle per entry)
import counter_pkg::*;

module down_counter #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             hold,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             reload_go;
  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_dec;

  // A zero reload value would just re-enter DONE; treat it as a stop.
  assign reload_go = (state == S_DONE) && auto_reload && (reload_reg != '0);

  always_comb begin
    cnt_ld  = load | reload_go;
    cnt_val = load ? load_val : reload_reg;
    cnt_dec = !load && (state == S_COUNT) && !hold;
  end

  dcnt_reg #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (RESET),
    .ld     (cnt_ld),
    .ld_val (cnt_val),
    .dec    (cnt_dec),
    .q      (q)
  );

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= S_IDLE;
      reload_reg <= '0;
    end else if (load) begin
      state      <= S_IDLE;
      reload_reg <= load_val;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= (q != '0) ? S_COUNT : S_DONE;
        // The 1->0 decrement and the move to DONE share an edge.
        S_COUNT: if (!hold && q == WIDTH'(1)) state <= S_DONE;
        S_DONE:  state <= reload_go ? S_COUNT : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_COUNT) || (state == S_DONE);
  assign tc   = (state == S_DONE);

endmodule

// File: tb/tb_down_counter.sv
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         RESET;
  logic         load, start, hold, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         busy, tc;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = idle, 1 = counting, 2 = terminal
  int m_q, m_rl, m_ph;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .hold        (hold),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .tc          (tc)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rl = 0; m_ph = 0;
  endtask

  task automatic model_step();
    if (load) begin
      m_q = int'(load_val); m_rl = int'(load_val); m_ph = 0;
    end else if (m_ph == 0) begin
      if (start) m_ph = (m_q != 0) ? 1 : 2;
    end else if (m_ph == 1) begin
      if (!hold && m_q > 0) begin
        m_q = m_q - 1;
        if (m_q == 0) m_ph = 2;
      end
    end else begin
      if (auto_reload && m_rl != 0) begin
        m_q = m_rl; m_ph = 1;
      end else m_ph = 0;
    end
  endtask

  // One clock edge, then compare outputs against the model.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("q",    int'(q),    m_q);
    chk("busy", int'(busy), int'(m_ph != 0));
    chk("tc",   int'(tc),   int'(m_ph == 2));
  endtask

  // Edge plus directed expectation from the scenario tables.
  task automatic step_exp(input string tag, input int eq, input int eb, input int et);
    tick();
    chk({tag, ".q"},    int'(q),    eq);
    chk({tag, ".busy"}, int'(busy), eb);
    chk({tag, ".tc"},   int'(tc),   et);
  endtask

  task automatic idle_in();
    load = 0; start = 0; hold = 0; auto_reload = 0; load_val = '0;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    model_reset();
    #1;
    chk("rst.q",    int'(q),    0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.tc",   int'(tc),   0);
    @(posedge clk);
    #1 RESET = 1'b1;
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = W'(v);
    step_exp("load", v, 0, 0);
    load = 0;
  endtask

  initial begin
    int seq_h[8];
    idle_in();
    RESET = 1'b0;
    model_reset();
    #3;
    chk("por.q",    int'(q),    0);
    chk("por.busy", int'(busy), 0);
    chk("por.tc",   int'(tc),   0);
    @(posedge clk);
    #1 RESET = 1'b1;

    // Basic countdown 3,2,1,0
    do_load(3);
    start = 1;
    step_exp("basic", 3, 1, 0);
    start = 0;
    step_exp("basic", 2, 1, 0);
    step_exp("basic", 1, 1, 0);
    step_exp("basic", 0, 1, 1);
    step_exp("basic.idle", 0, 0, 0);

    // Hold for two cycles at q=3
    seq_h = '{5, 4, 3, 3, 3, 2, 1, 0};
    do_load(5);
    start = 1;
    for (int i = 0; i < 8; i++) begin
      hold = (i == 3 || i == 4);
      step_exp("hold", seq_h[i], 1, int'(i == 7));
      start = 0;
    end
    hold = 0;
    step_exp("hold.idle", 0, 0, 0);

    // Auto-reload 2,1,0,2,1,0,2
    do_load(2);
    auto_reload = 1; start = 1;
    for (int i = 0; i < 7; i++) begin
      step_exp("arl", 2 - (i % 3), 1, int'(i % 3 == 2));
      start = 0;
    end
    auto_reload = 0;
    step_exp("arl.q1", 1, 1, 0);
    step_exp("arl.q0", 0, 1, 1);
    step_exp("arl.idle", 0, 0, 0);

    // Zero start: single DONE cycle
    do_load(0);
    start = 1;
    step_exp("zero", 0, 1, 1);
    start = 0;
    step_exp("zero.idle", 0, 0, 0);

    // Load aborts a running count, start alongside is ignored
    do_load(15);
    start = 1;
    step_exp("abort", 15, 1, 0);
    start = 0;
    step_exp("abort", 14, 1, 0);
    step_exp("abort", 13, 1, 0);
    step_exp("abort", 12, 1, 0);
    load = 1; load_val = 4'd7; start = 1;
    step_exp("abort.ld", 7, 0, 0);
    load = 0; start = 0;
    step_exp("abort.idle", 7, 0, 0);

    // Reset mid-count, no clock edge needed
    do_load(9);
    start = 1;
    step_exp("rmid", 9, 1, 0);
    start = 0;
    step_exp("rmid", 8, 1, 0);
    step_exp("rmid", 7, 1, 0);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load        = ($urandom_range(0, 15) == 0);
      load_val    = W'($urandom);
      start       = $urandom_range(0, 1) == 1;
      hold        = ($urandom_range(0, 3) == 0);
      auto_reload = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
